// File: rtl/csr_dec_row_expand.sv
// CSR row decoder: expands (nnz count, col/value stream) rows into dense
// N_COLS-long rows, one column per cycle, zero-filling absent columns.
module csr_dec_row_expand #(
    parameter int DATA_W = 14,
    parameter int COL_W  = 8,
    parameter int N_COLS = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     len_valid,
    output logic                     len_ready,
    input  logic [COL_W:0]           len,
    input  logic                     elem_valid,
    output logic                     elem_ready,
    input  logic [COL_W-1:0]         elem_col,
    input  logic signed [DATA_W-1:0] elem_val,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [COL_W-1:0]         out_col,
    output logic                     out_last,
    input  logic                     err_clr,
    output logic                     err,
    output logic [CNT_W-1:0]         rows_done
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DRAIN
    } state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);
    localparam logic [COL_W:0]   N_MAX    = (COL_W + 1)'(N_COLS);

    state_t                     state;
    state_t                     state_nxt;
    logic [COL_W-1:0]           col;
    logic [COL_W-1:0]           col_nxt;
    logic [COL_W:0]             nnz_left;
    logic [COL_W:0]             nnz_nxt;
    logic [COL_W:0]             nnz_dec;
    logic                       adv;
    logic                       emit;
    logic                       err_set;
    logic                       row_end;
    logic signed [DATA_W-1:0]   emit_data;

    assign adv     = !out_valid || out_ready;
    assign nnz_dec = nnz_left - 1'b1;

    always_comb begin
        state_nxt  = state;
        col_nxt    = col;
        nnz_nxt    = nnz_left;
        len_ready  = 1'b0;
        elem_ready = 1'b0;
        emit       = 1'b0;
        emit_data  = '0;
        err_set    = 1'b0;
        row_end    = 1'b0;
        case (state)
            IDLE: begin
                len_ready = reset;
                if (len_valid && len_ready) begin
                    state_nxt = EXPAND;
                    col_nxt   = '0;
                    if (len > N_MAX) begin
                        nnz_nxt = N_MAX;
                        err_set = 1'b1;
                    end else begin
                        nnz_nxt = len;
                    end
                end
            end
            EXPAND: begin
                if (adv) begin
                    // with elements still owed, a missing element stalls:
                    // we cannot tell a zero column from a late value
                    if (nnz_left == '0) begin
                        emit = 1'b1;
                    end else if (elem_valid) begin
                        if (elem_col == col) begin
                            emit       = 1'b1;
                            emit_data  = elem_val;
                            elem_ready = 1'b1;
                            nnz_nxt    = nnz_dec;
                        end else if (elem_col > col) begin
                            emit = 1'b1;
                        end else begin
                            elem_ready = 1'b1;
                            nnz_nxt    = nnz_dec;
                            err_set    = 1'b1;
                        end
                    end
                    if (emit) begin
                        if (col == LAST_COL) begin
                            col_nxt   = '0;
                            row_end   = 1'b1;
                            state_nxt = (nnz_nxt == '0) ? IDLE : DRAIN;
                        end else begin
                            col_nxt = col + 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                elem_ready = elem_valid;
                if (elem_valid) begin
                    nnz_nxt = nnz_dec;
                    err_set = 1'b1;
                    if (nnz_dec == '0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            col       <= '0;
            nnz_left  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
            rows_done <= '0;
        end else begin
            state    <= state_nxt;
            col      <= col_nxt;
            nnz_left <= nnz_nxt;
            if (adv) begin
                out_valid <= emit;
                if (emit) begin
                    out_data <= emit_data;
                    out_col  <= col;
                    out_last <= (col == LAST_COL);
                end
            end
            if (row_end) rows_done <= rows_done + 1'b1;
            if (err_set) err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule
